// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronises and debounces the Rs.5/Rs.10 sensors and
// turns each clean insertion into one coin code pulse, or a reject pulse.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sense_5,
  input  logic             sense_10,
  input  logic             inhibit,
  output logic [1:0]       coin,
  output logic             reject,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  // Channel index 0 is Rs.5 and index 1 is Rs.10, so a single rise maps directly to its coin code
  logic [1:0]     r_meta;
  logic [1:0]     r_sync;
  logic [1:0]     r_deb;
  logic [1:0]     r_debD;
  logic [DBW-1:0] r_dbCnt [2];
  logic [1:0]     w_rise;

  state_t         r_state;
  state_t         w_stateNxt;
  logic [GW-1:0]  r_gapCnt;
  logic [GW-1:0]  w_gapNxt;
  logic [1:0]     r_coin;
  logic [1:0]     w_coinNxt;
  logic           r_reject;
  logic           w_rejectNxt;
  logic [1:0]     w_inc;
  logic [CNT_W-1:0] r_cnt5;
  logic [CNT_W-1:0] r_cnt10;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_deb      <= '0;
      r_debD     <= '0;
      r_dbCnt[0] <= '0;
      r_dbCnt[1] <= '0;
    end else begin
      r_meta <= {sense_10, sense_5};
      r_sync <= r_meta;
      r_debD <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_deb[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i]   <= ~r_deb[i];
          r_dbCnt[i] <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_rise = r_deb & ~r_debD;

  always_comb begin
    w_stateNxt  = r_state;
    w_gapNxt    = r_gapCnt;
    w_coinNxt   = 2'b00;
    w_rejectNxt = 1'b0;
    w_inc       = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_rise != 2'b00) begin
          if (w_rise == 2'b11 || inhibit) begin
            w_rejectNxt = 1'b1;
            w_stateNxt  = GAP;
            w_gapNxt    = '0;
          end else begin
            w_coinNxt  = w_rise;
            w_stateNxt = EMIT;
          end
        end
      end
      EMIT: begin
        w_inc       = r_coin;
        w_rejectNxt = |w_rise;
        w_stateNxt  = GAP;
        w_gapNxt    = '0;
      end
      GAP: begin
        // Leaving needs both the quiet period and both sensors released, so a held coin cannot re-trigger
        w_rejectNxt = |w_rise;
        if (r_gapCnt != GW'(GAP_CYCLES)) begin
          w_gapNxt = r_gapCnt + GW'(1);
        end else if (r_deb == 2'b00) begin
          w_stateNxt = IDLE;
        end
      end
      default: begin
        w_stateNxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_gapCnt <= '0;
      r_coin   <= 2'b00;
      r_reject <= 1'b0;
      r_cnt5   <= '0;
      r_cnt10  <= '0;
    end else begin
      r_state  <= w_stateNxt;
      r_gapCnt <= w_gapNxt;
      r_coin   <= w_coinNxt;
      r_reject <= w_rejectNxt;
      if (w_inc[0] && (r_cnt5 != '1)) begin
        r_cnt5 <= r_cnt5 + CNT_W'(1);
      end
      if (w_inc[1] && (r_cnt10 != '1)) begin
        r_cnt10 <= r_cnt10 + CNT_W'(1);
      end
    end
  end

  assign coin   = r_coin;
  assign reject = r_reject;
  assign busy   = (r_state != IDLE);
  assign cnt_5  = r_cnt5;
  assign cnt_10 = r_cnt10;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: a behavioural model predicts coin and
// reject pulses, busy and tallies; a monitor compares them every cycle.
module tb_coin_acceptor;

  localparam int D   = 4;
  localparam int G   = 2;
  localparam int W   = 2;
  localparam int MAXC = (1 << W) - 1;
  localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sense_5 = 1'b0;
  logic         sense_10 = 1'b0;
  logic         inhibit = 1'b0;
  logic [1:0]   coin;
  logic         reject;
  logic         busy;
  logic [W-1:0] cnt_5;
  logic [W-1:0] cnt_10;

  int checks = 0;
  int errors = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .sense_5(sense_5), .sense_10(sense_10),
    .inhibit(inhibit), .coin(coin), .reject(reject), .busy(busy),
    .cnt_5(cnt_5), .cnt_10(cnt_10)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int code; int rej; } ev_t;
  ev_t expQ[$];

  // Model state: raw samples age through two flops, a level changes once the last D samples all disagree
  int          mCycle = 0;
  logic [1:0]  mMeta, mSync, mDeb, mDebD;
  logic [31:0] hist [2];
  int          mPhase = 0;
  int          mGapEdges = 0;
  int          mShown = 0;
  int          mCnt5 = 0;
  int          mCnt10 = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushEvent(input int code, input int rej);
    ev_t e;
    e.cyc = mCycle;
    e.code = code;
    e.rej = rej;
    expQ.push_back(e);
  endtask

  task automatic modelStep();
    logic [1:0] rise;
    logic [1:0] debOld;
    if (!reset) begin
      mMeta = '0; mSync = '0; mDeb = '0; mDebD = '0;
      hist[0] = '0; hist[1] = '0;
      mPhase = 0; mGapEdges = 0; mShown = 0; mCnt5 = 0; mCnt10 = 0;
      expQ.delete();
      return;
    end
    mCycle++;
    rise = mDeb & ~mDebD;
    debOld = mDeb;
    for (int i = 0; i < 2; i++) begin
      hist[i] = {hist[i][30:0], mSync[i]};
      if ((hist[i] & MASK) == (debOld[i] ? 32'd0 : MASK)) mDeb[i] = ~debOld[i];
    end
    mDebD = debOld;
    mSync = mMeta;
    mMeta = {sense_10, sense_5};
    if (mPhase == 0) begin
      if (rise != 2'b00) begin
        if (rise == 2'b11 || inhibit) begin
          pushEvent(0, 1);
          mPhase = 2;
          mGapEdges = 0;
        end else begin
          mShown = (rise == 2'b01) ? 1 : 2;
          pushEvent(mShown, 0);
          mPhase = 1;
        end
      end
    end else if (mPhase == 1) begin
      if (mShown == 1) mCnt5 = (mCnt5 < MAXC) ? mCnt5 + 1 : MAXC;
      else mCnt10 = (mCnt10 < MAXC) ? mCnt10 + 1 : MAXC;
      if (rise != 2'b00) pushEvent(0, 1);
      mPhase = 2;
      mGapEdges = 0;
    end else begin
      if (rise != 2'b00) pushEvent(0, 1);
      if (mGapEdges >= G && debOld == 2'b00) mPhase = 0;
      else mGapEdges++;
    end
  endtask

  task automatic monitorStep();
    bit dutEv;
    ev_t e;
    dutEv = (coin != 2'b00) || reject;
    if (expQ.size() > 0 && expQ[0].cyc <= mCycle) begin
      e = expQ.pop_front();
      checkOutput("event coin", int'(coin), e.code);
      checkOutput("event reject", int'(reject), e.rej);
    end else if (dutEv) begin
      checkOutput("unexpected coin/reject", int'({coin, reject}), 0);
    end
    checkOutput("busy", int'(busy), (mPhase != 0) ? 1 : 0);
    checkOutput("cnt_5", int'(cnt_5), mCnt5);
    checkOutput("cnt_10", int'(cnt_10), mCnt10);
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (reset) monitorStep();
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    waitCycles(3);
    reset = 1'b1;
  endtask

  // kind: 0 Rs.5, 1 Rs.10, 2 bouncy Rs.10, 3 both at once, 4 short Rs.5 glitch, 5 Rs.5 then overlapping Rs.10
  task automatic applyStimulus(input int kind, input int hold, input bit inh);
    inhibit = inh;
    case (kind)
      0: begin sense_5 = 1'b1; waitCycles(hold); sense_5 = 1'b0; end
      1: begin sense_10 = 1'b1; waitCycles(hold); sense_10 = 1'b0; end
      2: begin
        repeat (2) begin
          sense_10 = 1'b1; waitCycles(1);
          sense_10 = 1'b0; waitCycles(1);
        end
        sense_10 = 1'b1; waitCycles(hold); sense_10 = 1'b0;
      end
      3: begin
        sense_5 = 1'b1; sense_10 = 1'b1; waitCycles(hold);
        sense_5 = 1'b0; sense_10 = 1'b0;
      end
      4: begin sense_5 = 1'b1; waitCycles($urandom_range(1, D - 1)); sense_5 = 1'b0; end
      default: begin
        sense_5 = 1'b1; waitCycles(hold / 2 + 1);
        sense_10 = 1'b1; waitCycles(hold);
        sense_5 = 1'b0; sense_10 = 1'b0;
      end
    endcase
    inhibit = 1'b0;
  endtask

  initial begin
    int n;
    waitCycles(3);
    checkOutput("reset coin", int'(coin), 0);
    checkOutput("reset reject", int'(reject), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset cnt_5", int'(cnt_5), 0);
    checkOutput("reset cnt_10", int'(cnt_10), 0);
    reset = 1'b1;
    waitCycles(2);

    $display("[TB] clean Rs.5 coin and latency");
    sense_5 = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (coin == 2'b00 && n < 30);
    checkOutput("latency edges", n, D + 3);
    checkOutput("first coin code", int'(coin), 1);
    waitCycles(14);
    sense_5 = 1'b0;
    waitCycles(15);
    checkOutput("test1 cnt_5", int'(cnt_5), 1);
    checkOutput("test1 busy idle", int'(busy), 0);

    $display("[TB] bouncy Rs.10 and short glitches");
    applyStimulus(2, 15, 1'b0);
    waitCycles(15);
    checkOutput("test2 cnt_10", int'(cnt_10), 1);
    repeat (3) begin
      sense_5 = 1'b1; waitCycles(2);
      sense_5 = 1'b0; waitCycles(4);
    end
    waitCycles(10);
    checkOutput("test2 cnt_5 unchanged", int'(cnt_5), 1);

    $display("[TB] simultaneous coins");
    doReset();
    applyStimulus(3, 10, 1'b0);
    waitCycles(15);
    checkOutput("test3 cnt_5", int'(cnt_5), 0);
    checkOutput("test3 cnt_10", int'(cnt_10), 0);

    $display("[TB] inhibit");
    applyStimulus(1, 12, 1'b1);
    waitCycles(15);
    checkOutput("test4 inhibited cnt_10", int'(cnt_10), 0);
    applyStimulus(1, 12, 1'b0);
    waitCycles(15);
    checkOutput("test4 accepted cnt_10", int'(cnt_10), 1);

    $display("[TB] second coin during gap");
    sense_5 = 1'b1;
    waitCycles(9);
    sense_10 = 1'b1;
    waitCycles(8);
    sense_5 = 1'b0;
    sense_10 = 1'b0;
    waitCycles(15);
    checkOutput("test5 cnt_5", int'(cnt_5), 1);
    checkOutput("test5 cnt_10 after gap reject", int'(cnt_10), 1);
    applyStimulus(1, 10, 1'b0);
    waitCycles(15);
    checkOutput("test5 cnt_10 fresh coin", int'(cnt_10), 2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 100; i++) begin
      applyStimulus($urandom_range(0, 5), $urandom_range(3, 16), ($urandom_range(0, 4) == 0));
      waitCycles($urandom_range(0, 12));
    end
    waitCycles(20);

    $display("[TB] saturation and async reset");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 12, 1'b0);
      waitCycles(8);
      checkOutput("saturating cnt_5", int'(cnt_5), (i + 1 > MAXC) ? MAXC : i + 1);
    end
    sense_5 = 1'b1;
    n = 0;
    while (coin == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sixth coin shown", int'(coin), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset coin", int'(coin), 0);
    checkOutput("async reset reject", int'(reject), 0);
    checkOutput("async reset cnt_5", int'(cnt_5), 0);
    checkOutput("async reset cnt_10", int'(cnt_10), 0);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(12);
    sense_5 = 1'b0;
    waitCycles(12);
    checkOutput("held sensor fresh coin", int'(cnt_5), 1);

    waitCycles(30);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end coin validator that drives the 2-bit coin code consumed by the newspaper vending FSM.
- Synchronises and debounces two raw slot sensors (Rs.5, Rs.10).
- Emits exactly one single-cycle coin code per physical coin.
- Rejects coins that arrive while the vending FSM is dispensing (inhibit) or that are ambiguous.
- Keeps saturating accepted-coin tallies for audit.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples needed to change a debounced level (D, >=2)
GAP_CYCLES, 2, minimum idle cycles after any coin/reject before the next event can be accepted (G, >=1)
CNT_W, 8, width of accepted-coin counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
sense_5  input  1  raw Rs.5 slot sensor, asynchronous, bouncy, high while coin present
sense_10  input  1  raw Rs.10 slot sensor, asynchronous, bouncy, high while coin present
inhibit  input  1  high while vending FSM is dispensing (tie to newspaper); coins must not be forwarded
coin  output  2  00 none, 01 Rs.5, 10 Rs.10; registered; nonzero for exactly one cycle per accepted coin; never 11
reject  output  1  registered one-cycle pulse, drives coin-return flap
busy  output  1  high when FSM is not IDLE
cnt_5  output  CNT_W  accepted Rs.5 coins, saturating
cnt_10  output  CNT_W  accepted Rs.10 coins, saturating

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE.
  - Synchroniser flops, debounced levels, delayed levels and all counters cleared.
  - Reset mid-pulse aborts the coin.
  - A sensor still held high after release is treated as a fresh coin after full debounce.
- Synchroniser: two flops per sensor. Nothing downstream uses raw inputs.
- Debounce, per channel:
  - Counter increments while sync level != debounced level; clears when they are equal.
  - When D consecutive differing samples are seen, the debounced level toggles and the counter clears.
  - Glitches shorter than D cycles are ignored.
- Rise detect: rise_x = deb_x & ~deb_x_d, where deb_x_d is the registered previous value.
- FSM states IDLE, EMIT, GAP:
  - IDLE, exactly one rise, inhibit=0: go to EMIT; coin <= code next cycle.
  - IDLE, both rises in the same cycle: reject <= 1, go to GAP, no coin, no count.
  - IDLE, any rise with inhibit=1: reject <= 1, go to GAP, no coin.
  - EMIT: coin returns to 00; increment the matching counter (hold at all-ones); go to GAP.
  - GAP: count G cycles.
    - Return to IDLE only when G has elapsed AND both debounced levels are 0.
    - Otherwise stay in GAP; counter holds at G.
- Any rise seen while in EMIT or GAP: reject pulse 1 cycle, no state change, no coin, no count.
- Latency: raw input stable high first sampled at edge k gives coin nonzero in the cycle following edge k+D+2 (D=4: after edge k+6). Coin drops at the next edge.
- inhibit is sampled only on the rise cycle. Inhibit rising after EMIT is entered does not cancel the coin.
- coin and reject are never both high in the same cycle.
- Counter width rule: pure CNT_W-bit; no wrap (saturate at 2^CNT_W-1).

Test Plan:
1. Reset low, then high; sense_5 high for 20 cycles, clean -> coin=01 for exactly 1 cycle after edge k+6; cnt_5=1; busy high until 2 cycles after sense_5 debounces low; reject never.
2. sense_10 bouncing (1,0,1,0, then steady 1 for 15 cycles) -> one coin=10 pulse only; cnt_10=1; 2-cycle glitches on sense_5 -> no event.
3. sense_5 and sense_10 rising on the same edge, both held 10 cycles -> reject=1 for 1 cycle; coin stays 00; both counters 0.
4. inhibit=1 held while sense_10 inserted -> reject pulse, coin 00, cnt_10 unchanged. Repeat with inhibit=0 -> coin=10.
5. sense_5 coin accepted, then sense_10 rising while still in GAP (sense_5 still high) -> reject pulse, no coin=10. After both released plus G cycles, a new sense_10 -> coin=10.
6. CNT_W=2: insert 5 Rs.5 coins -> cnt_5 = 1, 2, 3, 3, 3 (saturates). Pull reset low during the EMIT cycle of a 6th coin -> coin, reject and counters read 0 immediately (async).
